turfio_cin_parallel_sync_v3: RTL and testbench

Parametrised per-lane CIN deserialiser/aligner on the TURF side of the TURFIO link. It takes an NBITS-wide parallel stream per IFCLK, applies a bit slip, and assembles NBEATS-beat frames aligned to the IFCLK phase marker. It adds an autonomous training FSM that hunts bit-slip positions against TRAIN_SEQUENCE and reports lock or fail. It also provides a saturating bit-error counter. One instance sits per CIN lane, between the IDELAY/ISERDES front end and the command decoder.

---
 rtl/turfio_cin_parallel_sync_v3.sv | 219 +++++++++++++++++++++
 tb/tb_turfio_cin_parallel_sync_v3.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/turfio_cin_parallel_sync_v3.sv
// Per-lane CIN deserialiser/aligner: bit slip, phase-aligned frame capture,
// autonomous bit-slip training and a saturating bit-error counter.
module turfio_cin_parallel_sync_v3 #(
    parameter int NBITS  = 4,
    parameter int NBEATS = 8,
    parameter logic [NBITS*NBEATS-1:0] TRAIN_SEQUENCE = 32'hA55A6996,
    parameter int NMATCH = 4,
    parameter     CLKTYPE = "IFCLK67",
    localparam int FW = NBITS * NBEATS,
    localparam int SW = (NBITS > 1) ? $clog2(NBITS) : 1,
    localparam int PW = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
    input  logic          ifclk_i,
    input  logic          rst_i,
    input  logic          ifclk_phase_i,
    input  logic [PW-1:0] offset_i,
    input  logic [NBITS-1:0] cin_i,
    input  logic          train_i,
    input  logic          bitslip_i,
    input  logic          enable_i,
    input  logic          capture_i,
    input  logic          captured_i,
    output logic [FW-1:0] cin_parallel_o,
    output logic          cin_parallel_valid_o,
    output logic          locked_o,
    output logic          train_fail_o,
    output logic [SW-1:0] slip_o,
    output logic          biterr_o,
    output logic [15:0]   biterr_count_o
);

    localparam int TW = $clog2(NBITS + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_FLUSH, ST_CHECK, ST_SLIP, ST_LOCKED, ST_FAIL
    } state_t;

    if ((NBEATS & (NBEATS - 1)) != 0 || CLKTYPE == 0) begin : g_param_check
        $error("NBEATS must be a power of 2 and CLKTYPE must name a clock");
    end

    logic [NBITS-1:0]   cin_q;
    logic [2*NBITS-1:0] window;
    logic [NBITS-1:0]   aligned;
    logic [FW-NBITS-1:0] history_q;
    logic [FW-1:0]      frame;

    logic [PW-1:0] phase_cnt_q;
    logic          phase_seen_q;
    logic          cap_en_q;

    logic          hold_q;
    (* CUSTOM_CC_DST = CLKTYPE *)
    logic [FW-1:0] capture_q;
    logic          valid_q;

    state_t        state_q, state_d;
    logic [SW-1:0] slip_q, slip_d, slip_inc;
    logic [TW-1:0] tries_q, tries_d;
    logic [3:0]    mcount_q, mcount_d;
    logic          flush_q, flush_d;
    logic          locked_q, locked_d;
    logic          fail_q, fail_d;

    logic [NBITS-1:0] srl_q [NBEATS];
    logic          biterr_d, biterr_q;
    logic [15:0]   count_q;

    // Window spans the previous and current word so any slip stays contiguous.
    assign window   = {cin_i, cin_q};
    assign aligned  = window[slip_q +: NBITS];
    assign frame    = {aligned, history_q};
    assign slip_inc = (slip_q == SW'(NBITS - 1)) ? '0 : slip_q + SW'(1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge ifclk_i or posedge rst_i) begin
        if (rst_i) begin
            cin_q     <= '0;
            history_q <= '0;
        end else begin
            cin_q     <= cin_i;
            history_q <= frame[FW-1:NBITS];
        end
    end

    always_ff @(posedge ifclk_i or posedge rst_i) begin
        if (rst_i) begin
            phase_cnt_q  <= '0;
            phase_seen_q <= 1'b0;
            cap_en_q     <= 1'b0;
        end else begin
            phase_cnt_q  <= ifclk_phase_i ? PW'(1) : phase_cnt_q + PW'(1);
            phase_seen_q <= phase_seen_q | ifclk_phase_i;
            cap_en_q     <= phase_seen_q && (phase_cnt_q == offset_i);
        end
    end

    always_ff @(posedge ifclk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_q    <= 1'b0;
            capture_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            if (capture_i)       hold_q <= 1'b1;
            else if (captured_i) hold_q <= 1'b0;
            if (cap_en_q && !capture_i && !hold_q) capture_q <= frame;
            valid_q <= cap_en_q && enable_i;
        end
    end

    always_ff @(posedge ifclk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            slip_q   <= '0;
            tries_q  <= '0;
            mcount_q <= '0;
            flush_q  <= 1'b0;
            locked_q <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            slip_q   <= slip_d;
            tries_q  <= tries_d;
            mcount_q <= mcount_d;
            flush_q  <= flush_d;
            locked_q <= locked_d;
            fail_q   <= fail_d;
        end
    end

    // NOTE: every next-state signal is defaulted to its current value first,
    // so no path through the case statement can infer a latch.
    always_comb begin
        state_d  = state_q;
        slip_d   = slip_q;
        tries_d  = tries_q;
        mcount_d = mcount_q;
        flush_d  = flush_q;
        locked_d = locked_q;
        fail_d   = fail_q;
        if (train_i) begin
            state_d  = ST_FLUSH;
            slip_d   = '0;
            tries_d  = '0;
            mcount_d = '0;
            flush_d  = 1'b0;
            locked_d = 1'b0;
            fail_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_LOCKED, ST_FAIL: begin
                    if (bitslip_i) slip_d = slip_inc;
                end
                ST_FLUSH: begin
                    // Two strobes guarantee the history holds only post-slip beats.
                    if (cap_en_q) begin
                        flush_d = ~flush_q;
                        if (flush_q) state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (cap_en_q) begin
                        if (frame == TRAIN_SEQUENCE) begin
                            mcount_d = mcount_q + 4'd1;
                            if (mcount_q == 4'(NMATCH - 1)) begin
                                locked_d = 1'b1;
                                state_d  = ST_LOCKED;
                            end
                        end else begin
                            mcount_d = '0;
                            state_d  = ST_SLIP;
                        end
                    end
                end
                ST_SLIP: begin
                    slip_d  = slip_inc;
                    tries_d = tries_q + TW'(1);
                    if (tries_q + TW'(1) == TW'(NBITS)) begin
                        fail_d  = 1'b1;
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign biterr_d = !enable_i && (history_q[NBITS-1:0] != srl_q[NBEATS-1]);

    // NOTE: the delay line is reset, unlike a plain SRL, so the error check
    // starts from a known history instead of comparing against stale contents.
    always_ff @(posedge ifclk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NBEATS; i++) srl_q[i] <= '0;
            biterr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            srl_q[0] <= history_q[NBITS-1:0];
            for (int i = 1; i < NBEATS; i++) srl_q[i] <= srl_q[i-1];
            biterr_q <= biterr_d;
            if (train_i)
                count_q <= '0;
            else if (biterr_d && count_q != 16'hFFFF)
                count_q <= count_q + 16'd1;
        end
    end

    assign cin_parallel_o       = capture_q;
    assign cin_parallel_valid_o = valid_q;
    assign locked_o             = locked_q;
    assign train_fail_o         = fail_q;
    assign slip_o               = slip_q;
    assign biterr_o             = biterr_q;
    assign biterr_count_o       = count_q;

endmodule

// File: tb/tb_turfio_cin_parallel_sync_v3.sv
// Directed bench for turfio_cin_parallel_sync_v3: training, capture freeze,
// bit-error counting and asynchronous reset behaviour.
module tb_turfio_cin_parallel_sync_v3;

    localparam logic [31:0] TRAIN = 32'hA55A6996;

    logic        ifclk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        ifclk_phase_i = 1'b0;
    logic [2:0]  offset_i = 3'd7;
    logic [3:0]  cin_i = 4'h0;
    logic        train_i = 1'b0;
    logic        bitslip_i = 1'b0;
    logic        enable_i = 1'b1;
    logic        capture_i = 1'b0;
    logic        captured_i = 1'b0;
    logic [31:0] cin_parallel_o;
    logic        cin_parallel_valid_o;
    logic        locked_o;
    logic        train_fail_o;
    logic [1:0]  slip_o;
    logic        biterr_o;
    logic [15:0] biterr_count_o;

    turfio_cin_parallel_sync_v3 dut (
        .ifclk_i(ifclk_i), .rst_i(rst_i), .ifclk_phase_i(ifclk_phase_i),
        .offset_i(offset_i), .cin_i(cin_i), .train_i(train_i),
        .bitslip_i(bitslip_i), .enable_i(enable_i), .capture_i(capture_i),
        .captured_i(captured_i), .cin_parallel_o(cin_parallel_o),
        .cin_parallel_valid_o(cin_parallel_valid_o), .locked_o(locked_o),
        .train_fail_o(train_fail_o), .slip_o(slip_o), .biterr_o(biterr_o),
        .biterr_count_o(biterr_count_o)
    );

    always #5 ifclk_i = ~ifclk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int mode     = 0;   // 0: training word stream, 1: random, 2: pattern table
    int delay    = 0;
    bit phase_en = 1'b1;
    logic [31:0] train_word = TRAIN;
    logic [3:0]  pat [8];

    // Serial stream carries the training word repeatedly, delayed by dly bits.
    function automatic logic [3:0] train_beat(input int c, input int dly);
        logic [3:0] b;
        int n;
        for (int j = 0; j < 4; j++) begin
            n = 4 * c + j - dly;
            n = ((n % 32) + 32) % 32;
            b[j] = train_word[n];
        end
        return b;
    endfunction

    initial begin
        forever begin
            @(posedge ifclk_i);
            #1;
            cyc++;
            ifclk_phase_i = phase_en && (cyc % 8 == 0);
            case (mode)
                0:       cin_i = train_beat(cyc, delay);
                1:       cin_i = 4'($urandom);
                default: cin_i = pat[cyc % 8];
            endcase
        end
    end

    task automatic wait_cyc_mod(input int m);
        @(negedge ifclk_i);
        while (cyc % 8 != m) @(negedge ifclk_i);
    endtask

    task automatic pulse_train();
        wait_cyc_mod(3);
        train_i = 1'b1;
        @(negedge ifclk_i);
        train_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge ifclk_i);
        n_checks++;
        if (cin_parallel_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_parallel got %h want %h", cin_parallel_o, 32'h0);
        end
        n_checks++;
        if ({cin_parallel_valid_o, locked_o, train_fail_o, slip_o, biterr_o, biterr_count_o} !== 22'h0) begin
            n_fail++;
            $display("FAIL reset_status got v=%b l=%b f=%b s=%0d e=%b c=%0d want all 0",
                     cin_parallel_valid_o, locked_o, train_fail_o, slip_o, biterr_o, biterr_count_o);
        end
        rst_i = 1'b0;
        repeat (20) @(negedge ifclk_i);
    endtask

    task automatic test_lock_no_slip();
        int frames;
        bit got;
        frames = 0;
        got = 1'b0;
        mode = 0;
        delay = 0;
        repeat (16) @(negedge ifclk_i);
        pulse_train();
        for (int i = 0; i < 200; i++) begin
            @(negedge ifclk_i);
            if (cin_parallel_valid_o) frames++;
            if (locked_o) begin
                got = 1'b1;
                break;
            end
        end
        n_checks++;
        if (got !== 1'b1) begin n_fail++; $display("FAIL lock0_timeout got %b want 1", got); end
        n_checks++;
        if (frames !== 6) begin n_fail++; $display("FAIL lock0_frames got %0d want 6", frames); end
        n_checks++;
        if (slip_o !== 2'd0) begin n_fail++; $display("FAIL lock0_slip got %0d want 0", slip_o); end
        n_checks++;
        if (cin_parallel_o !== TRAIN) begin
            n_fail++; $display("FAIL lock0_frame got %h want %h", cin_parallel_o, TRAIN);
        end
        n_checks++;
        if (train_fail_o !== 1'b0) begin n_fail++; $display("FAIL lock0_fail got %b want 0", train_fail_o); end
    endtask

    task automatic test_manual_slip();
        bit got;
        got = 1'b0;
        @(negedge ifclk_i);
        bitslip_i = 1'b1;
        @(negedge ifclk_i);
        bitslip_i = 1'b0;
        n_checks++;
        if ({locked_o, slip_o} !== 3'b1_01) begin
            n_fail++; $display("FAIL manual_slip_locked got l=%b s=%0d want l=1 s=1", locked_o, slip_o);
        end
        wait_cyc_mod(3);
        train_i = 1'b1;
        bitslip_i = 1'b1;
        @(negedge ifclk_i);
        train_i = 1'b0;
        bitslip_i = 1'b0;
        n_checks++;
        if ({locked_o, slip_o} !== 3'b0_00) begin
            n_fail++; $display("FAIL slip_with_train got l=%b s=%0d want l=0 s=0", locked_o, slip_o);
        end
        @(negedge ifclk_i);
        bitslip_i = 1'b1;
        @(negedge ifclk_i);
        bitslip_i = 1'b0;
        n_checks++;
        if (slip_o !== 2'd0) begin n_fail++; $display("FAIL slip_in_flush got %0d want 0", slip_o); end
        for (int i = 0; i < 200; i++) begin
            @(negedge ifclk_i);
            if (locked_o) begin
                got = 1'b1;
                break;
            end
        end
        n_checks++;
        if ({got, slip_o} !== 3'b1_00) begin
            n_fail++; $display("FAIL relock got l=%b s=%0d want l=1 s=0", got, slip_o);
        end
    endtask

    task automatic test_capture_freeze();
        bit stable;
        bit got;
        stable = 1'b1;
        got = 1'b0;
        wait_cyc_mod(3);
        capture_i = 1'b1;
        for (int k = 0; k < 8; k++) pat[k] = 4'(k + 1);
        mode = 2;
        repeat (20) begin
            @(negedge ifclk_i);
            if (cin_parallel_o !== TRAIN) stable = 1'b0;
        end
        capture_i = 1'b0;
        wait_cyc_mod(3);
        if (cin_parallel_o !== TRAIN) stable = 1'b0;
        captured_i = 1'b1;
        @(negedge ifclk_i);
        captured_i = 1'b0;
        n_checks++;
        if (stable !== 1'b1 || cin_parallel_o !== TRAIN) begin
            n_fail++; $display("FAIL freeze_hold got %h want %h", cin_parallel_o, TRAIN);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge ifclk_i);
            if (cin_parallel_valid_o) begin
                got = 1'b1;
                break;
            end
        end
        n_checks++;
        if (got !== 1'b1 || cin_parallel_o !== 32'h87654321) begin
            n_fail++; $display("FAIL freeze_release got %h valid_seen=%b want 87654321", cin_parallel_o, got);
        end
    endtask

    task automatic test_biterr();
        int pulses;
        int valids;
        int k;
        pulses = 0;
        valids = 0;
        enable_i = 1'b0;
        repeat (10) begin
            @(negedge ifclk_i);
            if (biterr_o) pulses++;
        end
        for (int n = 0; n < 3; n++) begin
            k = (n == 0) ? 2 : (n == 1) ? 5 : 1;
            pat[k] = pat[k] ^ 4'hF;
            repeat (24) begin
                @(negedge ifclk_i);
                if (biterr_o) pulses++;
            end
        end
        n_checks++;
        if (pulses !== 3) begin n_fail++; $display("FAIL biterr_pulses got %0d want 3", pulses); end
        n_checks++;
        if (biterr_count_o !== 16'd3) begin n_fail++; $display("FAIL biterr_count got %0d want 3", biterr_count_o); end
        enable_i = 1'b1;
        pat[3] = pat[3] ^ 4'hF;
        pulses = 0;
        repeat (32) begin
            @(negedge ifclk_i);
            if (cin_parallel_valid_o) valids++;
            if (biterr_o) pulses++;
        end
        n_checks++;
        if (valids !== 4) begin n_fail++; $display("FAIL enable_valids got %0d want 4", valids); end
        n_checks++;
        if (pulses !== 0 || biterr_count_o !== 16'd3) begin
            n_fail++; $display("FAIL enable_suppress got pulses=%0d count=%0d want 0 and 3", pulses, biterr_count_o);
        end
        pulse_train();
        n_checks++;
        if (biterr_count_o !== 16'd0) begin n_fail++; $display("FAIL biterr_clear got %0d want 0", biterr_count_o); end
    endtask

    task automatic test_skew(input int dly, input logic [1:0] exp_slip);
        bit got;
        got = 1'b0;
        mode = 0;
        delay = dly;
        repeat (16) @(negedge ifclk_i);
        pulse_train();
        for (int i = 0; i < 400; i++) begin
            @(negedge ifclk_i);
            if (locked_o || train_fail_o) begin
                got = locked_o;
                break;
            end
        end
        n_checks++;
        if ({got, train_fail_o, slip_o} !== {1'b1, 1'b0, exp_slip}) begin
            n_fail++;
            $display("FAIL skew%0d_lock got l=%b f=%b s=%0d want l=1 f=0 s=%0d",
                     dly, got, train_fail_o, slip_o, exp_slip);
        end
        n_checks++;
        if (cin_parallel_o !== TRAIN) begin
            n_fail++; $display("FAIL skew%0d_frame got %h want %h", dly, cin_parallel_o, TRAIN);
        end
    endtask

    task automatic test_garbage();
        bit got;
        got = 1'b0;
        mode = 1;
        repeat (8) @(negedge ifclk_i);
        pulse_train();
        for (int i = 0; i < 400; i++) begin
            @(negedge ifclk_i);
            if (train_fail_o || locked_o) begin
                got = train_fail_o;
                break;
            end
        end
        n_checks++;
        if ({got, locked_o, slip_o} !== 4'b1_0_00) begin
            n_fail++; $display("FAIL garbage got f=%b l=%b s=%0d want f=1 l=0 s=0", got, locked_o, slip_o);
        end
    endtask

    task automatic test_reset_mid_check();
        bit got;
        int vcount;
        int seen;
        got = 1'b0;
        vcount = 0;
        seen = 0;
        mode = 0;
        delay = 3;
        repeat (16) @(negedge ifclk_i);
        pulse_train();
        for (int i = 0; i < 300; i++) begin
            @(negedge ifclk_i);
            if (slip_o == 2'd2) begin
                got = 1'b1;
                break;
            end
        end
        for (int i = 0; i < 40 && vcount < 2; i++) begin
            @(negedge ifclk_i);
            if (cin_parallel_valid_o) vcount++;
        end
        n_checks++;
        if (got !== 1'b1 || vcount !== 2) begin
            n_fail++; $display("FAIL midcheck_reach got slip2=%b frames=%0d want 1 and 2", got, vcount);
        end
        repeat (2) @(negedge ifclk_i);
        #2;
        rst_i = 1'b1;
        #1;
        n_checks++;
        if (cin_parallel_o !== 32'h0) begin
            n_fail++; $display("FAIL async_reset_parallel got %h want 0", cin_parallel_o);
        end
        n_checks++;
        if ({cin_parallel_valid_o, locked_o, train_fail_o, slip_o, biterr_o, biterr_count_o} !== 22'h0) begin
            n_fail++;
            $display("FAIL async_reset_status got v=%b l=%b f=%b s=%0d e=%b c=%0d want all 0",
                     cin_parallel_valid_o, locked_o, train_fail_o, slip_o, biterr_o, biterr_count_o);
        end
        phase_en = 1'b0;
        repeat (3) @(negedge ifclk_i);
        rst_i = 1'b0;
        repeat (30) begin
            @(negedge ifclk_i);
            if (cin_parallel_valid_o) seen++;
        end
        n_checks++;
        if (seen !== 0 || locked_o !== 1'b0) begin
            n_fail++; $display("FAIL no_phase_valid got valids=%0d locked=%b want 0 and 0", seen, locked_o);
        end
        phase_en = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge ifclk_i);
            if (cin_parallel_valid_o) begin
                got = 1'b1;
                break;
            end
        end
        n_checks++;
        if (got !== 1'b1) begin n_fail++; $display("FAIL phase_return_valid got %b want 1", got); end
    endtask

    initial begin
        test_reset();
        test_lock_no_slip();
        test_manual_slip();
        test_capture_freeze();
        test_biterr();
        test_skew(1, 2'd1);
        test_skew(3, 2'd3);
        test_garbage();
        test_reset_mid_check();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
